spram_arb: RTL and testbench

Parametrised multi-channel single-port synchronous RAM with byte-lane write enables and round-robin arbitration. CHANNELS requesters share one RAM port: one access is granted per cycle, and read data returns one cycle later with a per-channel valid strobe. It sits between CPU-side and peripheral-side masters (e.g. core data bus plus a DMA/debug port) and a single block RAM, and generalises the plain single-port RAM used elsewhere in the design.

---
 rtl/spram_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/spram_arb.sv | 90 +++++++++
 tb/tb_spram_arb.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared constants and helpers for the arbitrated single-port RAM.
// Configuration checks are done at elaboration time in spram_arb.
package spram_pkg;

    function automatic int lanes(input int data_w, input int lane_w);
        return data_w / lane_w;
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit cfg_ok(input int data_w, input int lane_w, input int ch);
        return (lane_w > 0) && (data_w % lane_w == 0) && (ch >= 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: the search starts one past ptr and wraps around.
// This block holds no state; the parent owns the pointer register.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;
    int   c;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = PW'(c);
            end
        end
    end

endmodule

// File: rtl/spram_arb.sv
// Multi-channel single-port RAM: one round-robin grant per cycle,
// per-lane write enables, and registered read data with a per-channel strobe.
module spram_arb
    import spram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8,
    parameter int CHANNELS   = 2
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic [CHANNELS-1:0]                                req,
    input  logic [CHANNELS-1:0]                                wr,
    input  logic [CHANNELS*ADDR_WIDTH-1:0]                     addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0]                     din,
    input  logic [CHANNELS*lanes(DATA_WIDTH, LANE_WIDTH)-1:0]  be,
    output logic [CHANNELS-1:0]                                gnt,
    output logic [DATA_WIDTH-1:0]                              dout,
    output logic [CHANNELS-1:0]                                rvalid
);

    localparam int LANES = lanes(DATA_WIDTH, LANE_WIDTH);
    localparam int PW    = ptr_w(CHANNELS);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!cfg_ok(DATA_WIDTH, LANE_WIDTH, CHANNELS)) begin : g_cfg_err
        $error("spram_arb: DATA_WIDTH must be a multiple of LANE_WIDTH and CHANNELS >= 1");
    end

    logic [PW-1:0]         ptr_q, ptr_d, gnt_idx;
    logic [DATA_WIDTH-1:0] dout_q, dout_d, rd_word;
    logic [CHANNELS-1:0]   rvalid_q, rvalid_d;

    logic                  acc, wr_en, rd_en;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;
    logic [LANES-1:0]      sel_be;

    rr_arbiter #(.N(CHANNELS), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    // Route the winning channel's request fields onto the single RAM port.
    always_comb begin
        acc      = |req;
        sel_addr = addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_din  = din[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_be   = be[int'(gnt_idx)*LANES +: LANES];
        wr_en    = acc & wr[gnt_idx];
        rd_en    = acc & ~wr[gnt_idx];
    end

    // One array per lane so each lane maps onto its own write-enabled RAM column.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LANE_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge clk) begin
            if (rst_n && wr_en && sel_be[l])
                mem[sel_addr] <= sel_din[l*LANE_WIDTH +: LANE_WIDTH];
        end

        assign rd_word[l*LANE_WIDTH +: LANE_WIDTH] = mem[sel_addr];
    end

    always_comb begin
        ptr_d    = acc   ? gnt_idx : ptr_q;
        dout_d   = rd_en ? rd_word : dout_q;
        rvalid_d = rd_en ? gnt     : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= PW'(CHANNELS - 1);
            dout_q   <= '0;
            rvalid_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            dout_q   <= dout_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign dout   = dout_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_spram_arb.sv
// Directed bench: a 2-channel instance for data-path checks and a
// 3-channel instance for round-robin rotation.
module tb_spram_arb;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [1:0]  req, wr, gnt, rvalid;
    logic [19:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic [15:0] dout;

    logic [2:0]  req3, wr3, gnt3, rvalid3;
    logic [29:0] addr3;
    logic [47:0] din3;
    logic [5:0]  be3;
    logic [15:0] dout3;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spram_arb #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .LANE_WIDTH(8), .CHANNELS(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .din(din),
        .be(be), .gnt(gnt), .dout(dout), .rvalid(rvalid)
    );

    spram_arb #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .LANE_WIDTH(8), .CHANNELS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .wr(wr3), .addr(addr3), .din(din3),
        .be(be3), .gnt(gnt3), .dout(dout3), .rvalid(rvalid3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input bit r, input bit w, input logic [9:0] a,
                          input logic [15:0] d, input logic [1:0] b);
        req[c]           = r;
        wr[c]            = w;
        addr[c*10 +: 10] = a;
        din[c*16 +: 16]  = d;
        be[c*2 +: 2]     = b;
    endtask

    localparam logic [2:0] RR_EXP [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        rst_n = 1'b0;
        req = '0; wr = '0; addr = '0; din = '0; be = '0;
        req3 = '0; wr3 = '0; addr3 = '0; din3 = '0; be3 = '0;

        // reset with both channels requesting reads
        set_ch(0, 1, 0, 10'd0, 16'h0, 2'b11);
        set_ch(1, 1, 0, 10'd0, 16'h0, 2'b11);
        tick(); tick();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_gnt", 32'(gnt), 32'h1);

        // release reset mid-cycle; both write, ch0 wins first
        set_ch(0, 1, 1, 10'd5, 16'hBEEF, 2'b11);
        set_ch(1, 1, 1, 10'd7, 16'h7777, 2'b11);
        rst_n = 1'b1;
        #1 chk("rel_gnt", 32'(gnt), 32'h1);
        tick();
        set_ch(0, 1, 1, 10'd5, 16'h1234, 2'b10);
        #1 chk("rr2_gnt", 32'(gnt), 32'h2);
        tick();
        chk("wr_no_rvalid", 32'(rvalid), 32'h0);
        set_ch(1, 0, 0, 10'd0, 16'h0, 2'b00);
        #1 chk("lane_wr_gnt", 32'(gnt), 32'h1);
        tick();

        // byte-lane merge read back by ch1
        set_ch(0, 0, 0, 10'd0, 16'h0, 2'b00);
        set_ch(1, 1, 0, 10'd5, 16'h0, 2'b00);
        #1 chk("rd5_gnt", 32'(gnt), 32'h2);
        tick();
        chk("rd5_dout", 32'(dout), 32'h12EF);
        chk("rd5_rvalid", 32'(rvalid), 32'h2);
        set_ch(1, 0, 0, 10'd0, 16'h0, 2'b00);
        #1 chk("idle_gnt", 32'(gnt), 32'h0);
        tick();
        chk("idle_rvalid", 32'(rvalid), 32'h0);
        chk("idle_dout", 32'(dout), 32'h12EF);

        // write top address, read it back the next cycle
        set_ch(1, 1, 1, 10'h3FF, 16'h00A5, 2'b11);
        #1 chk("wtop_gnt", 32'(gnt), 32'h2);
        tick();
        set_ch(1, 0, 0, 10'd0, 16'h0, 2'b00);
        set_ch(0, 1, 0, 10'h3FF, 16'h0, 2'b00);
        #1 chk("rtop_gnt", 32'(gnt), 32'h1);
        tick();
        chk("rtop_dout", 32'(dout), 32'h00A5);
        chk("rtop_rvalid", 32'(rvalid), 32'h1);

        // be=0 write is a no-op but still advances the pointer
        set_ch(0, 1, 1, 10'd7, 16'h0000, 2'b00);
        #1 chk("noop_gnt", 32'(gnt), 32'h1);
        tick();
        set_ch(0, 1, 0, 10'd5, 16'h0, 2'b00);
        set_ch(1, 1, 0, 10'd7, 16'h0, 2'b00);
        #1 chk("both_gnt", 32'(gnt), 32'h2);
        tick();
        chk("rd7_dout", 32'(dout), 32'h7777);
        chk("rd7_rvalid", 32'(rvalid), 32'h2);
        set_ch(1, 0, 0, 10'd0, 16'h0, 2'b00);
        #1 chk("b2b_gnt", 32'(gnt), 32'h1);
        tick();
        chk("b2b_dout", 32'(dout), 32'h12EF);
        chk("b2b_rvalid", 32'(rvalid), 32'h1);
        set_ch(0, 0, 0, 10'd0, 16'h0, 2'b00);
        tick();
        chk("hold1_rvalid", 32'(rvalid), 32'h0);
        tick();
        chk("hold2_dout", 32'(dout), 32'h12EF);

        // reset asserted during a granted read
        set_ch(1, 1, 0, 10'h3FF, 16'h0, 2'b00);
        #1 chk("mid_gnt", 32'(gnt), 32'h2);
        #2 rst_n = 1'b0;
        #1 chk("mid_async_dout", 32'(dout), 32'h0);
        tick();
        chk("mid_rvalid", 32'(rvalid), 32'h0);
        chk("mid_dout", 32'(dout), 32'h0);
        // write attempted while reset is held must be dropped
        set_ch(1, 0, 0, 10'd0, 16'h0, 2'b00);
        set_ch(0, 1, 1, 10'd5, 16'hFFFF, 2'b11);
        #1 chk("rstwr_gnt", 32'(gnt), 32'h1);
        tick();
        rst_n = 1'b1;
        set_ch(0, 1, 0, 10'd5, 16'h0, 2'b00);
        tick();
        chk("post_rd5", 32'(dout), 32'h12EF);
        chk("post_rv5", 32'(rvalid), 32'h1);
        set_ch(0, 1, 0, 10'h3FF, 16'h0, 2'b00);
        tick();
        chk("post_rdtop", 32'(dout), 32'h00A5);
        set_ch(0, 0, 0, 10'd0, 16'h0, 2'b00);

        // three channels requesting continuously rotate one grant per cycle
        req3 = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1 chk($sformatf("rr3_gnt%0d", i), 32'(gnt3), 32'(RR_EXP[i]));
            tick();
            chk($sformatf("rr3_rv%0d", i), 32'(rvalid3), 32'(RR_EXP[i]));
        end
        req3 = '0;
        tick();
        chk("rr3_idle_rv", 32'(rvalid3), 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
